// File: rtl/vc_fifo_mem_if.sv
// Push/pop bus of the virtual-channel FIFO memory.
// The classifier/arbiter side drives through 'master'; the memory sits on 'slave'.
interface vc_fifo_mem_if #(
  parameter int DATA_SIZE = 10,
  parameter int NUM_VC    = 2,
  parameter int VC_W      = (NUM_VC > 1) ? $clog2(NUM_VC) : 1
);
  // push side
  logic                 push;
  logic [VC_W-1:0]      push_vc;
  logic [DATA_SIZE-1:0] data_in;
  // pop side
  logic                 pop;
  logic [VC_W-1:0]      pop_vc;
  logic [DATA_SIZE-1:0] data_out;
  logic                 valid_out;
  // per-VC status
  logic [NUM_VC-1:0]    full;
  logic [NUM_VC-1:0]    empty;
  logic [NUM_VC-1:0]    almost_full;
  logic [NUM_VC-1:0]    almost_empty;
  // sticky errors
  logic                 overflow_err;
  logic                 underflow_err;

  modport master (
    output push, push_vc, data_in, pop, pop_vc,
    input  data_out, valid_out, full, empty, almost_full, almost_empty,
           overflow_err, underflow_err
  );

  modport slave (
    input  push, push_vc, data_in, pop, pop_vc,
    output data_out, valid_out, full, empty, almost_full, almost_empty,
           overflow_err, underflow_err
  );
endinterface

// File: rtl/vc_fifo_mem.sv
// Multi-VC circular FIFO memory: NUM_VC independent FIFOs of 2**ADDR_W words
// sharing one storage array addressed as {vc, ptr}, 1-cycle registered read.

// Per-VC pointer/occupancy tracker with flag decode.
module vc_fifo_ctl #(
  parameter int ADDR_W    = 2,
  parameter int AF_THRESH = 3,
  parameter int AE_THRESH = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inc_i,
  input  logic              dec_i,
  output logic [ADDR_W-1:0] wr_ptr_o,
  output logic [ADDR_W-1:0] rd_ptr_o,
  output logic              full_o,
  output logic              empty_o,
  output logic              afull_o,
  output logic              aempty_o
);
  localparam int CNT_W = ADDR_W + 1;
  localparam int DEPTH = 1 << ADDR_W;

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  // Next-state: pointers wrap naturally on ADDR_W bits; simultaneous
  // push+pop leaves the count alone.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (inc_i) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
    if (dec_i) rd_ptr_d = rd_ptr_q + ADDR_W'(1);
    case ({inc_i, dec_i})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // State registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign wr_ptr_o = wr_ptr_q;
  assign rd_ptr_o = rd_ptr_q;
  assign full_o   = (cnt_q == CNT_W'(DEPTH));
  assign empty_o  = (cnt_q == '0);
  assign afull_o  = (cnt_q >= CNT_W'(AF_THRESH));
  assign aempty_o = (cnt_q <= CNT_W'(AE_THRESH));
endmodule

module vc_fifo_mem #(
  parameter int DATA_SIZE = 10,
  parameter int ADDR_W    = 2,
  parameter int NUM_VC    = 2,
  parameter int AF_THRESH = 3,
  parameter int AE_THRESH = 1
) (
  input  logic         clk,
  input  logic         reset,
  vc_fifo_mem_if.slave bus
);
  localparam int VC_W  = (NUM_VC > 1) ? $clog2(NUM_VC) : 1;
  localparam int MEM_N = NUM_VC << ADDR_W;
  localparam int MA_W  = VC_W + ADDR_W;

  logic [NUM_VC-1:0][ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [NUM_VC-1:0]             full_v, empty_v, afull_v, aempty_v;
  logic [NUM_VC-1:0]             inc_v, dec_v;

  logic push_vc_ok, pop_vc_ok;
  logic push_acc, pop_acc;
  logic [MA_W-1:0] wr_addr, rd_addr;

  logic [DATA_SIZE-1:0] mem_q [MEM_N];
  logic [DATA_SIZE-1:0] data_out_q;
  logic                 valid_q;
  logic                 ovf_q, unf_q;

  // Channel-number range check only exists when the VC field has spare codes.
  if ((1 << VC_W) == NUM_VC) begin : g_vc_pow2
    assign push_vc_ok = 1'b1;
    assign pop_vc_ok  = 1'b1;
  end else begin : g_vc_npow2
    assign push_vc_ok = (int'(bus.push_vc) < NUM_VC);
    assign pop_vc_ok  = (int'(bus.pop_vc)  < NUM_VC);
  end

  // Pop never bypasses a same-cycle push; a full VC takes a push only if it
  // is being drained by an accepted pop in the same cycle.
  assign pop_acc  = bus.pop && pop_vc_ok && !empty_v[bus.pop_vc];
  assign push_acc = bus.push && push_vc_ok &&
                    (!full_v[bus.push_vc] || (pop_acc && (bus.pop_vc == bus.push_vc)));

  assign wr_addr = {bus.push_vc, wr_ptr[bus.push_vc]};
  assign rd_addr = {bus.pop_vc,  rd_ptr[bus.pop_vc]};

  for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
    assign inc_v[v] = push_acc && (bus.push_vc == VC_W'(v));
    assign dec_v[v] = pop_acc  && (bus.pop_vc  == VC_W'(v));

    vc_fifo_ctl #(
      .ADDR_W    (ADDR_W),
      .AF_THRESH (AF_THRESH),
      .AE_THRESH (AE_THRESH)
    ) u_ctl (
      .clk      (clk),
      .rst      (reset),
      .inc_i    (inc_v[v]),
      .dec_i    (dec_v[v]),
      .wr_ptr_o (wr_ptr[v]),
      .rd_ptr_o (rd_ptr[v]),
      .full_o   (full_v[v]),
      .empty_o  (empty_v[v]),
      .afull_o  (afull_v[v]),
      .aempty_o (aempty_v[v])
    );
  end

  // Storage write; contents survive reset. A full-VC push+pop reads the old
  // word at this edge while the new word lands in the same slot.
  always_ff @(posedge clk) begin
    if (push_acc) mem_q[wr_addr] <= bus.data_in;
  end

  // Registered read port: data holds between pops, valid pulses per pop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_out_q <= '0;
      valid_q    <= 1'b0;
    end else begin
      valid_q <= pop_acc;
      if (pop_acc) data_out_q <= mem_q[rd_addr];
    end
  end

  // Sticky error flags: any dropped push / rejected pop, cleared only by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_q | (bus.push && !push_acc);
      unf_q <= unf_q | (bus.pop  && !pop_acc);
    end
  end

  assign bus.data_out      = data_out_q;
  assign bus.valid_out     = valid_q;
  assign bus.full          = full_v;
  assign bus.empty         = empty_v;
  assign bus.almost_full   = afull_v;
  assign bus.almost_empty  = aempty_v;
  assign bus.overflow_err  = ovf_q;
  assign bus.underflow_err = unf_q;
endmodule
